// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU types and constants for the HI/LO sequencer
package cpu_pkg;

    // Sequencer states; ARM covers the cycle in which the unit latches its operands.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        MULT_ARM  = 3'd1,
        MULT_WAIT = 3'd2,
        DIV_ARM   = 3'd3,
        DIV_WAIT  = 3'd4
    } hilo_state_t;

    // Start edge to op_done rising edge for a multiply.
    localparam int MULT_LATENCY = 35;

    // Result pattern the Div unit presents on a divide by zero.
    localparam logic [31:0] DIV0_VALUE = 32'h7FFF_FFFF;

endpackage

// File: rtl/hilo_sequencer.sv
// rtl/hilo_sequencer.sv - multiply/divide initiator owning the HI/LO registers
module hilo_sequencer
    import cpu_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start_mult,
    input  logic        start_div,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
    input  logic        mult_done,
    input  logic [31:0] mult_hi,
    input  logic [31:0] mult_lo,
    input  logic        div_done,
    input  logic        div0,
    input  logic [31:0] div_hi,
    input  logic [31:0] div_lo,
    output logic        mult_ctrl,
    output logic        div_ctrl,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        op_done,
    output logic        div0_exc
);

    hilo_state_t state;

    // Sequencer FSM plus HI/LO capture; op_done/div0_exc are single-cycle pulses.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            hi       <= 32'd0;
            lo       <= 32'd0;
            op_done  <= 1'b0;
            div0_exc <= 1'b0;
        end else begin
            op_done  <= 1'b0;
            div0_exc <= 1'b0;
            case (state)
                IDLE: begin
                    // A write in the same cycle as a start lands now and is overwritten by the result.
                    if (mthi) hi <= wdata;
                    if (mtlo) lo <= wdata;
                    if (start_mult) begin
                        state <= MULT_ARM;
                    end else if (start_div) begin
                        state <= DIV_ARM;
                    end
                end
                // Done may still be high from the previous operation, so ARM never looks at it.
                MULT_ARM: state <= MULT_WAIT;
                MULT_WAIT: begin
                    if (mult_done) begin
                        hi      <= mult_hi;
                        lo      <= mult_lo;
                        op_done <= 1'b1;
                        state   <= IDLE;
                    end
                end
                DIV_ARM: state <= DIV_WAIT;
                DIV_WAIT: begin
                    if (div_done) begin
                        if (div0) begin
                            div0_exc <= 1'b1;
                        end else begin
                            hi <= div_hi;
                            lo <= div_lo;
                        end
                        op_done <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Ctrl drops in the Done cycle so Mult does not re-init on the capture edge and Div can re-arm;
    // reset gates it so the units see ctrl low without waiting for the state to clear.
    always_comb begin
        mult_ctrl = 1'b0;
        div_ctrl  = 1'b0;
        if (!reset) begin
            mult_ctrl = (state == MULT_ARM) || ((state == MULT_WAIT) && !mult_done);
            div_ctrl  = (state == DIV_ARM)  || ((state == DIV_WAIT)  && !div_done);
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_hilo_sequencer.sv
// tb/tb_hilo_sequencer.sv - directed bench for hilo_sequencer with behavioural Mult/Div units
module tb_hilo_sequencer;
    import cpu_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        start_mult, start_div, mthi, mtlo;
    logic [31:0] wdata;
    logic        mult_done;
    logic [31:0] mult_hi, mult_lo;
    logic        div_done, div0;
    logic [31:0] div_hi, div_lo;
    logic        mult_ctrl, div_ctrl;
    logic [31:0] hi, lo;
    logic        busy, op_done, div0_exc;

    logic signed [31:0] reg_a, reg_b;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    hilo_sequencer dut (
        .clock     (clock),
        .reset     (reset),
        .start_mult(start_mult),
        .start_div (start_div),
        .mthi      (mthi),
        .mtlo      (mtlo),
        .wdata     (wdata),
        .mult_done (mult_done),
        .mult_hi   (mult_hi),
        .mult_lo   (mult_lo),
        .div_done  (div_done),
        .div0      (div0),
        .div_hi    (div_hi),
        .div_lo    (div_lo),
        .mult_ctrl (mult_ctrl),
        .div_ctrl  (div_ctrl),
        .hi        (hi),
        .lo        (lo),
        .busy      (busy),
        .op_done   (op_done),
        .div0_exc  (div0_exc)
    );

    function automatic logic [63:0] mul64(input logic signed [31:0] a, input logic signed [31:0] b);
        logic signed [63:0] x;
        logic signed [63:0] y;
        x = a;
        y = b;
        return x * y;
    endfunction

    function automatic logic [31:0] abs32(input logic signed [31:0] v);
        return (v < 0) ? -v : v;
    endfunction

    // Mult unit: inits when ctrl is high and it is not running, 32 iterations, Done one edge later.
    logic        m_run;
    logic [5:0]  m_cnt;
    logic [63:0] m_prod;
    always @(posedge clock) begin
        if (reset) begin
            m_run <= 1'b0; m_cnt <= 6'd0; m_prod <= 64'd0;
            mult_done <= 1'b0; mult_hi <= 32'd0; mult_lo <= 32'd0;
        end else if (mult_ctrl && !m_run) begin
            m_run <= 1'b1; m_cnt <= 6'd32; m_prod <= mul64(reg_a, reg_b);
            mult_done <= 1'b0; mult_hi <= 32'hDEAD_BEEF; mult_lo <= 32'hDEAD_BEEF;
        end else if (m_run) begin
            if (m_cnt == 6'd0) begin
                m_run <= 1'b0; mult_done <= 1'b1;
                mult_hi <= m_prod[63:32]; mult_lo <= m_prod[31:0];
            end else begin
                m_cnt <= m_cnt - 6'd1;
            end
        end
    end

    // Div unit: needs a ctrl-low cycle to re-arm; Done at E(N+2) for quotient magnitude N.
    logic        d_run, d_arm;
    logic [31:0] d_cnt, d_q, d_r;
    always @(posedge clock) begin
        if (reset) begin
            d_run <= 1'b0; d_arm <= 1'b1; d_cnt <= 32'd0; d_q <= 32'd0; d_r <= 32'd0;
            div_done <= 1'b0; div0 <= 1'b0; div_hi <= 32'd0; div_lo <= 32'd0;
        end else begin
            if (!div_ctrl) d_arm <= 1'b1;
            if (div_ctrl && d_arm && !d_run) begin
                d_arm <= 1'b0;
                if (reg_b == 32'sd0) begin
                    div_done <= 1'b1; div0 <= 1'b1;
                    div_hi <= DIV0_VALUE; div_lo <= DIV0_VALUE;
                end else begin
                    d_run <= 1'b1; div_done <= 1'b0; div0 <= 1'b0;
                    d_q <= reg_a / reg_b; d_r <= reg_a % reg_b;
                    d_cnt <= abs32(reg_a / reg_b);
                    div_hi <= 32'hDEAD_BEEF; div_lo <= 32'hDEAD_BEEF;
                end
            end else if (d_run) begin
                if (d_cnt == 32'd0) begin
                    d_run <= 1'b0; div_done <= 1'b1;
                    div_hi <= d_r; div_lo <= d_q;
                end else begin
                    d_cnt <= d_cnt - 32'd1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Pulse a start, then count edges after E0 until op_done is seen (bounded).
    task automatic run_op(input logic m, input logic d, output int lat, output logic ctrl_bad,
                          output logic arm_m, output logic arm_d, output logic div_seen);
        start_mult = m;
        start_div  = d;
        tick();
        start_mult = 1'b0;
        start_div  = 1'b0;
        arm_m    = mult_ctrl;
        arm_d    = div_ctrl;
        div_seen = div_ctrl;
        ctrl_bad = 1'b0;
        lat      = 0;
        while (!op_done && lat < 200) begin
            tick();
            lat++;
            if ((mult_done && mult_ctrl) || (div_done && div_ctrl)) ctrl_bad = 1'b1;
            if (div_ctrl) div_seen = 1'b1;
        end
    endtask

    initial begin
        int   lat;
        int   extra;
        logic ctrl_bad, arm_m, arm_d, div_seen;

        reset = 1'b1; start_mult = 1'b0; start_div = 1'b0;
        mthi = 1'b0; mtlo = 1'b0; wdata = 32'd0;
        reg_a = 32'sd0; reg_b = 32'sd0;
        tick(); tick();
        chk ("rst_hi", hi, 32'd0);
        chk ("rst_lo", lo, 32'd0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_op_done", op_done, 1'b0);
        chk1("rst_div0_exc", div0_exc, 1'b0);
        chk1("rst_mult_ctrl", mult_ctrl, 1'b0);
        chk1("rst_div_ctrl", div_ctrl, 1'b0);
        reset = 1'b0;
        tick();

        // 7 * -3 = -21
        reg_a = 32'sd7; reg_b = -32'sd3;
        run_op(1'b1, 1'b0, lat, ctrl_bad, arm_m, arm_d, div_seen);
        chk1("mul_arm_ctrl", arm_m, 1'b1);
        chk ("mul_latency", 32'(lat), 32'd35);
        chk ("mul_hi", hi, 32'hFFFF_FFFF);
        chk ("mul_lo", lo, 32'hFFFF_FFEB);
        chk1("mul_ctrl_drop", ctrl_bad, 1'b0);
        chk1("mul_busy_clear", busy, 1'b0);
        tick();
        chk1("mul_op_done_width", op_done, 1'b0);

        // 7 / -3: quotient -2, remainder 1
        run_op(1'b0, 1'b1, lat, ctrl_bad, arm_m, arm_d, div_seen);
        chk1("div_arm_ctrl", arm_d, 1'b1);
        chk ("div_latency", 32'(lat), 32'd5);
        chk ("div_lo", lo, 32'hFFFF_FFFE);
        chk ("div_hi", hi, 32'h0000_0001);
        chk1("div_ctrl_drop", ctrl_bad, 1'b0);
        chk1("div_no_exc", div0_exc, 1'b0);
        tick();

        // Divide by zero with HI/LO preloaded to 5/6
        mthi = 1'b1; wdata = 32'd5; tick();
        mthi = 1'b0; mtlo = 1'b1; wdata = 32'd6; tick();
        mtlo = 1'b0;
        chk ("mthi_write", hi, 32'd5);
        chk ("mtlo_write", lo, 32'd6);
        reg_b = 32'sd0;
        run_op(1'b0, 1'b1, lat, ctrl_bad, arm_m, arm_d, div_seen);
        chk ("div0_latency", 32'(lat), 32'd2);
        chk1("div0_exc_pulse", div0_exc, 1'b1);
        chk ("div0_hi_kept", hi, 32'd5);
        chk ("div0_lo_kept", lo, 32'd6);
        tick();
        chk1("div0_exc_width", div0_exc, 1'b0);

        // Back-to-back: 3*4, then 5*6 started in the op_done cycle
        reg_a = 32'sd3; reg_b = 32'sd4;
        run_op(1'b1, 1'b0, lat, ctrl_bad, arm_m, arm_d, div_seen);
        chk ("b2b_first_lo", lo, 32'd12);
        chk ("b2b_first_hi", hi, 32'd0);
        reg_a = 32'sd5; reg_b = 32'sd6;
        run_op(1'b1, 1'b0, lat, ctrl_bad, arm_m, arm_d, div_seen);
        chk ("b2b_second_latency", 32'(lat), 32'd35);
        chk ("b2b_second_lo", lo, 32'd30);
        chk1("b2b_ctrl_drop", ctrl_bad, 1'b0);
        tick();

        // Simultaneous start: multiply wins, divide dropped
        reg_a = 32'sd2; reg_b = 32'sd9;
        run_op(1'b1, 1'b1, lat, ctrl_bad, arm_m, arm_d, div_seen);
        chk1("both_mult_ctrl", arm_m, 1'b1);
        chk1("both_div_ctrl", arm_d, 1'b0);
        chk1("both_div_never", div_seen, 1'b0);
        chk ("both_latency", 32'(lat), 32'd35);
        chk ("both_lo", lo, 32'd18);
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (op_done) extra++;
        end
        chk ("both_single_op_done", 32'(extra), 32'd0);

        // Reset at E10 of a multiply; MTLO while busy must be ignored
        reg_a = 32'sd3; reg_b = 32'sd3;
        start_mult = 1'b1; tick(); start_mult = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        mtlo = 1'b1; wdata = 32'h0000_1234; tick();
        mtlo = 1'b0;
        chk ("mtlo_ignored_busy", lo, 32'd18);
        for (int i = 0; i < 4; i++) tick();
        reset = 1'b1;
        #1;
        chk1("rst_mid_ctrl_now", mult_ctrl, 1'b0);
        tick();
        reset = 1'b0;
        chk1("rst_mid_busy", busy, 1'b0);
        chk1("rst_mid_mult_ctrl", mult_ctrl, 1'b0);
        chk ("rst_mid_hi", hi, 32'd0);
        chk ("rst_mid_lo", lo, 32'd0);
        tick();
        reg_a = 32'sd2; reg_b = 32'sd2;
        run_op(1'b1, 1'b0, lat, ctrl_bad, arm_m, arm_d, div_seen);
        chk ("post_rst_latency", 32'(lat), 32'd35);
        chk ("post_rst_lo", lo, 32'd4);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
